sram_1rw_ctrl: RTL and testbench

SRAM_1RW_CTRL -- requirements
Module: sram_1rw_ctrl

---
 rtl/sram_ctrl_pkg.sv | 13 +
 rtl/sram_rsp_fifo.sv | 42 ++++
 rtl/sram_1rw_ctrl.sv | 62 ++++++
 tb/tb_sram_1rw_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared AW/DW/RSP_DEPTH defaults, request opcode and width helpers for the 1RW SRAM controller
package sram_ctrl_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 48;
  localparam int RSP_DEPTH_DEF = 3;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: DEPTH-entry read-response FIFO (push/push_data in, pop in, full/empty/head out), async active-high rst
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int DEPTH = RSP_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign head = mem[rd_q];
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= push_data;
  end
  assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/sram_1rw_ctrl.sv
// sram_1rw_ctrl: credit-limited valid/ready front end for a 1RW SRAM macro (req_* in, rsp_* out, sram_* macro pins)
module sram_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] sram_a,
  output logic          sram_csb,
  output logic          sram_web,
  output logic          sram_oeb,
  output logic [DW-1:0] sram_i,
  input  logic [DW-1:0] sram_o
);
  localparam int CW = cnt_w(RSP_DEPTH);
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, rd_inflight_q, hs, rd_hs, pop, empty, full;
  assign hs = req_valid && ready_q;
  assign rd_hs = hs && op_e'(req_write) == OP_READ;
  assign pop = rsp_valid && rsp_ready;
  assign cnt_d = cnt_q + CW'(rd_hs) - CW'(pop);
  assign req_ready = ready_q;
  assign sram_csb = ~hs;
  assign sram_web = ~req_write;
  assign sram_a = req_addr;
  assign sram_i = req_wdata;
  assign sram_oeb = ~rd_inflight_q;
  assign rsp_valid = !empty;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ready_q <= 1'b0;
      rd_inflight_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ready_q <= cnt_d < CW'(RSP_DEPTH);
      rd_inflight_q <= rd_hs;
    end
  end
  sram_rsp_fifo #(.DW(DW), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(rd_inflight_q),
    .push_data(sram_o),
    .pop(pop),
    .full(full),
    .empty(empty),
    .head(rsp_rdata)
  );
  assert property (@(posedge clk) disable iff (rst) full |-> cnt_q == CW'(RSP_DEPTH));
endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// tb_sram_1rw_ctrl: randomized and directed bench with SRAM macro model and in-order reference scoreboard
module tb_sram_1rw_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [7:0] req_addr = 0;
  logic [47:0] req_wdata = 0;
  logic req_ready, rsp_valid, sram_csb, sram_web, sram_oeb;
  logic [47:0] rsp_rdata, sram_i, sram_o, dout_q;
  logic [7:0] sram_a;
  int tests = 0, fails = 0, oeb_bad = 0;
  logic [47:0] sram_mem [256];
  logic [47:0] ref_mem [256];
  logic [47:0] exp_q [$];
  logic [47:0] got_q [$];
  bit seeded = 0, ref_seeded = 0, prev_rd = 0;

  sram_1rw_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .sram_a(sram_a), .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_oeb(sram_oeb), .sram_i(sram_i), .sram_o(sram_o)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] seed(input int a);
    return {16'hC0DE ^ 16'(a * 37), 16'(a), ~16'(a)};
  endfunction

  // SRAM macro: synchronous 1RW, output driven only while OEB is low
  assign sram_o = sram_oeb ? 'z : dout_q;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= seed(i);
      seeded <= 1;
    end else if (!sram_csb) begin
      if (!sram_web) sram_mem[sram_a] <= sram_i;
      else dout_q <= sram_mem[sram_a];
    end
  end

  // Reference: each accepted read returns the latest written value, in request order
  always @(negedge clk) begin
    if (!ref_seeded) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
      ref_seeded = 1;
    end
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      prev_rd = 0;
    end else begin
      if (sram_oeb !== ~prev_rd) oeb_bad++;
      if (rsp_valid && rsp_ready) got_q.push_back(rsp_rdata);
      if (req_valid && req_ready) begin
        if (req_write) ref_mem[req_addr] = req_wdata;
        else exp_q.push_back(ref_mem[req_addr]);
      end
      prev_rd = req_valid && req_ready && !req_write;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    rsp_ready = 1;
    req_valid = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!rsp_valid && sram_oeb && exp_q.size() == got_q.size()) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1; req_valid = 1; req_write = 0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (req_ready !== 0) begin fails++; $display("FAIL rst_ready: got %b required 0", req_ready); end
    tests++; if (rsp_valid !== 0) begin fails++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    tests++; if (sram_csb !== 1) begin fails++; $display("FAIL rst_csb: got %b required 1", sram_csb); end
    tests++; if (sram_oeb !== 1) begin fails++; $display("FAIL rst_oeb: got %b required 1", sram_oeb); end
    req_valid = 0; rst = 0;
    #1;
    tests++; if (req_ready !== 0) begin fails++; $display("FAIL rel_ready_early: got %b required 0", req_ready); end
    cyc();
    tests++; if (req_ready !== 1) begin fails++; $display("FAIL rel_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_write_read;
    bit ok;
    logic [47:0] e, g;
    rsp_ready = 0; req_valid = 1; req_write = 1; req_addr = 8'h10; req_wdata = 48'hA5A5_0000_1234;
    #1;
    tests++; if ({sram_csb, sram_web} !== 2'b00) begin fails++; $display("FAIL wr_ctrl: got csb/web %b required 00", {sram_csb, sram_web}); end
    tests++; if (sram_a !== 8'h10 || sram_i !== 48'hA5A5_0000_1234) begin fails++; $display("FAIL wr_bus: got a=%h i=%h required a=10 i=a5a500001234", sram_a, sram_i); end
    cyc();
    req_write = 0;
    #1;
    tests++; if ({sram_csb, sram_web} !== 2'b01) begin fails++; $display("FAIL rd_ctrl: got csb/web %b required 01", {sram_csb, sram_web}); end
    cyc();
    req_valid = 0;
    #1;
    tests++; if (rsp_valid !== 0 || sram_oeb !== 0 || sram_csb !== 1) begin fails++; $display("FAIL rd_n: got valid=%b oeb=%b csb=%b required 0 0 1", rsp_valid, sram_oeb, sram_csb); end
    cyc();
    tests++; if (rsp_valid !== 1 || rsp_rdata !== 48'hA5A5_0000_1234) begin fails++; $display("FAIL rd_n1: got valid=%b data=%h required 1 a5a500001234", rsp_valid, rsp_rdata); end
    tests++; if (sram_oeb !== 1) begin fails++; $display("FAIL rd_oeb_release: got %b required 1", sram_oeb); end
    drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL wr_rd_drain: got %0d responses required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL wr_rd_data: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back;
    int hs = 0;
    bit ok;
    logic [47:0] e, g;
    rsp_ready = 1; req_write = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1; req_addr = 8'(i);
      if (req_ready) hs++;
      cyc();
    end
    req_valid = 0;
    tests++; if (hs != 8) begin fails++; $display("FAIL b2b_handshakes: got %0d required 8", hs); end
    drain(ok);
    tests++; if (!ok || got_q.size() != 8) begin fails++; $display("FAIL b2b_count: got %0d responses required 8", got_q.size()); end
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL b2b_data: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_credit;
    int idx = 0;
    bit held = 0, ok;
    logic [47:0] d0 = 0, e, g;
    rsp_ready = 0; req_write = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = idx < 4; req_addr = 8'h20 + 8'(idx);
      if (req_valid && req_ready) idx++;
      cyc();
      if (held) begin
        tests++; if (rsp_valid !== 1 || rsp_rdata !== d0) begin fails++; $display("FAIL credit_hold: got valid=%b data=%h required 1 %h", rsp_valid, rsp_rdata, d0); end
      end else if (rsp_valid) begin
        held = 1; d0 = rsp_rdata;
        tests++; if (exp_q.size() == 0 || d0 !== exp_q[0]) begin fails++; $display("FAIL credit_head: got %h required ref of addr 20", d0); end
      end
    end
    tests++; if (idx != 3) begin fails++; $display("FAIL credit_accepted: got %0d required 3", idx); end
    tests++; if (req_ready !== 0) begin fails++; $display("FAIL credit_ready: got %b required 0", req_ready); end
    tests++; if (dut.cnt_q !== 2'd3) begin fails++; $display("FAIL credit_cnt: got %0d required 3", dut.cnt_q); end
    rsp_ready = 1;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      req_valid = 1; req_addr = 8'h20 + 8'(idx);
      if (req_ready) idx++;
      cyc();
    end
    req_valid = 0;
    tests++; if (idx != 4) begin fails++; $display("FAIL credit_resume: got %0d required 4", idx); end
    drain(ok);
    tests++; if (!ok || got_q.size() != 4) begin fails++; $display("FAIL credit_count: got %0d responses required 4", got_q.size()); end
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL credit_data: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wrap;
    bit wr [6] = '{1, 0, 0, 1, 0, 0};
    logic [7:0] ad [6] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic [47:0] v3 = 48'({$urandom(), $urandom()});
    logic [47:0] e, g;
    bit ok;
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_write = wr[i]; req_addr = ad[i];
      req_wdata = i == 0 ? 48'h1 : v3;
      cyc();
    end
    req_valid = 0; req_write = 0;
    drain(ok);
    tests++; if (!ok || got_q.size() != 4) begin fails++; $display("FAIL wrap_count: got %0d responses required 4", got_q.size()); end
    tests++; if (got_q.size() < 4 || got_q[0] !== 48'h1 || got_q[2] !== v3 || got_q[3] !== 48'h1) begin fails++; $display("FAIL wrap_values: got %0d entries first=%h required 1 then %h", got_q.size(), got_q.size() ? got_q[0] : 48'h0, v3); end
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL wrap_data: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random;
    int pend;
    bit ok;
    logic [47:0] e, g;
    for (int c = 0; c < 300; c++) begin
      pend = exp_q.size() - got_q.size();
      tests++; if (req_ready !== (pend < 3)) begin fails++; $display("FAIL rand_ready: got %b required %b at %0d in flight", req_ready, pend < 3, pend); end
      req_valid = $urandom_range(3) != 0; req_write = 1'($urandom_range(1));
      req_addr = 8'($urandom_range(15)); req_wdata = 48'({$urandom(), $urandom()});
      rsp_ready = $urandom_range(2) != 0;
      cyc();
    end
    req_valid = 0;
    drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rand_drain: got %0d responses required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL rand_data: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [47:0] e, g;
    rsp_ready = 0; req_write = 0;
    req_valid = 1; req_addr = 8'h30; cyc();
    req_addr = 8'h31; cyc();
    req_valid = 0; cyc(); cyc();
    tests++; if (rsp_valid !== 1) begin fails++; $display("FAIL mid_buffered: got %b required 1", rsp_valid); end
    req_valid = 1;
    #2 rst = 1;
    #1;
    tests++; if (rsp_valid !== 0 || sram_csb !== 1) begin fails++; $display("FAIL mid_rst: got valid=%b csb=%b required 0 1", rsp_valid, sram_csb); end
    tests++; if (req_ready !== 0 || sram_oeb !== 1) begin fails++; $display("FAIL mid_rst_ctrl: got ready=%b oeb=%b required 0 1", req_ready, sram_oeb); end
    req_valid = 0;
    cyc(); cyc();
    rst = 0;
    cyc();
    tests++; if (req_ready !== 1) begin fails++; $display("FAIL mid_ready: got %b required 1", req_ready); end
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests++; if (rsp_valid !== 0) begin fails++; $display("FAIL mid_stale: got %b required 0", rsp_valid); end
    end
    req_valid = 1; req_addr = 8'h10; cyc();
    req_valid = 0;
    drain(ok);
    tests++; if (!ok || got_q.size() != 1) begin fails++; $display("FAIL mid_count: got %0d responses required 1", got_q.size()); end
    while (exp_q.size() && got_q.size()) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL mid_data: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_oeb;
    tests++; if (oeb_bad != 0) begin fails++; $display("FAIL oeb_window: got %0d bad cycles required 0", oeb_bad); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_credit;
    test_wrap;
    test_random;
    test_reset_mid;
    test_oeb;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion required finish");
    $fatal(1);
  end
endmodule
